// File: rtl/imem_responder.sv
// Instruction-memory responder: a loader fills the word memory over a valid/ready
// handshake while fetch is stalled, then fetch reads it back with 1-cycle latency.
module imem_responder #(
   parameter int unsigned DEPTH_LOG2 = 16,
   parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           inst_addr_i,
   output logic [31:0]           inst_o,
   output logic                  stall_o,
   input  logic                  reload_i,
   input  logic                  load_valid_i,
   input  logic [31:0]           load_data_i,
   input  logic                  load_last_i,
   output logic                  load_ready_o,
   output logic [DEPTH_LOG2:0]   loaded_words_o,
   output logic                  load_err_o
);

   localparam int unsigned              DEPTH     = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0]    LAST_PTR  = DEPTH_LOG2'(DEPTH - 1);
   localparam logic [DEPTH_LOG2:0]      MAX_WORDS = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                  state_q,  state_d;
   logic [DEPTH_LOG2-1:0]   load_ptr_q, load_ptr_d;
   logic [DEPTH_LOG2:0]     words_q,  words_d;
   logic                    err_q,    err_d;
   logic                    load_accept;
   logic [DEPTH_LOG2-1:0]   fetch_idx;

   logic [31:0] mem [DEPTH];

   // High address bits are deliberately dropped so fetch addresses alias.
   assign fetch_idx = inst_addr_i[DEPTH_LOG2-1:0];

   if (DEPTH_LOG2 < 16) begin : g_alias
      logic unused_addr_high;
      assign unused_addr_high = ^inst_addr_i[15:DEPTH_LOG2];
   end

   // Handshake outputs depend on the state register only; reset just masks ready.
   assign load_ready_o   = rst && (state_q == LOAD);
   assign stall_o        = (state_q == LOAD);
   assign load_accept    = load_valid_i && load_ready_o;
   assign loaded_words_o = words_q;
   assign load_err_o     = err_q;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      load_ptr_d = load_ptr_q;
      words_d    = words_q;
      err_d      = err_q;
      unique case (state_q)
         LOAD: begin
            if (load_accept) begin
               load_ptr_d = load_ptr_q + 1'b1;
               if (words_q != MAX_WORDS) begin
                  words_d = words_q + 1'b1;
               end
               if (load_last_i) begin
                  state_d = RUN;
               end else if (load_ptr_q == LAST_PTR) begin
                  // Image filled the memory without a terminator.
                  state_d = RUN;
                  err_d   = 1'b1;
               end
            end
         end
         RUN: begin
            if (reload_i) begin
               state_d    = LOAD;
               load_ptr_d = '0;
               words_d    = '0;
               err_d      = 1'b0;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= LOAD;
         load_ptr_q <= '0;
         words_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_ptr_q <= load_ptr_d;
         words_q    <= words_d;
         err_q      <= err_d;
      end
   end

   // NOTE: the memory array has no reset, so a reload can overwrite only part of an image.
   always_ff @(posedge clk) begin
      if (load_accept) begin
         mem[load_ptr_q] <= load_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         inst_o <= NOP_INST;
      end else if (state_q == RUN && !reload_i) begin
         inst_o <= mem[fetch_idx];
      end else begin
         inst_o <= NOP_INST;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed test-plan scenarios plus random traffic,
// all compared against a word-level model of the load/run behaviour.
module tb_imem_responder;

   localparam int DL2   = 3;
   localparam int DEPTH = 2 ** DL2;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   inst_addr;
   logic [31:0]   inst;
   logic          stall;
   logic          reload;
   logic          load_valid;
   logic [31:0]   load_data;
   logic          load_last;
   logic          load_ready;
   logic [DL2:0]  loaded_words;
   logic          load_err;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: memory image plus the observable load/run status.
   logic [31:0] m_mem [DEPTH];
   bit          m_known [DEPTH];
   bit          m_init = 1'b0;
   bit          m_run;
   int          m_ptr, m_cnt;
   bit          m_err;
   logic [31:0] m_inst;
   bit          m_inst_known;

   imem_responder #(.DEPTH_LOG2(DL2), .NOP_INST(NOP)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .inst_addr_i    (inst_addr),
      .inst_o         (inst),
      .stall_o        (stall),
      .reload_i       (reload),
      .load_valid_i   (load_valid),
      .load_data_i    (load_data),
      .load_last_i    (load_last),
      .load_ready_o   (load_ready),
      .loaded_words_o (loaded_words),
      .load_err_o     (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: apply inputs, advance the model at the edge, compare half a cycle later.
   task automatic cyc(input bit r, input bit rl, input bit v, input logic [31:0] d,
                      input bit l, input logic [15:0] a);
      int idx;
      rst = r; reload = rl; load_valid = v; load_data = d; load_last = l; inst_addr = a;
      @(posedge clk);
      if (!r) begin
         m_init = 1'b1; m_run = 1'b0; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
         m_inst = NOP; m_inst_known = 1'b1;
      end else if (m_init && !m_run) begin
         m_inst = NOP; m_inst_known = 1'b1;
         if (v) begin
            m_mem[m_ptr] = d; m_known[m_ptr] = 1'b1;
            if (m_cnt < DEPTH) m_cnt++;
            if (l) m_run = 1'b1;
            else if (m_ptr == DEPTH - 1) begin m_run = 1'b1; m_err = 1'b1; end
            m_ptr = (m_ptr + 1) % DEPTH;
         end
      end else if (m_init) begin
         if (rl) begin
            m_run = 1'b0; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
            m_inst = NOP; m_inst_known = 1'b1;
         end else begin
            idx = int'(a) % DEPTH;
            m_inst = m_mem[idx]; m_inst_known = m_known[idx];
         end
      end
      @(negedge clk);
      if (m_init) begin
         check("stall", stall, !m_run);
         check("ready", load_ready, r ? !m_run : 1'b0);
         check("words", loaded_words, m_cnt);
         check("err", load_err, m_err);
         if (m_inst_known) check("inst", inst, m_inst);
      end
   endtask

   task automatic load_word(input logic [31:0] d, input bit l);
      cyc(1'b1, 1'b0, 1'b1, d, l, 16'($urandom));
   endtask

   task automatic gap();
      cyc(1'b1, 1'b0, 1'b0, $urandom, 1'b0, 16'($urandom));
   endtask

   // Loader lines are randomized during fetches: RUN must ignore them.
   task automatic fetch(input logic [15:0] a);
      cyc(1'b1, 1'b0, 1'($urandom), $urandom, 1'($urandom), a);
   endtask

   task automatic reload_pulse();
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0);
   endtask

   initial begin
      logic [31:0] img4 [4];
      img4 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

      // Reset state.
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 16'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_ready", load_ready, 1'b0);
      check("rst_words", loaded_words, 0);

      // Fetch while loading returns NOP and the loader is ready.
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
      check("loadfetch_inst", inst, 32'h0);
      check("loadfetch_ready", load_ready, 1'b1);
      check("loadfetch_stall", stall, 1'b1);

      // Four-word image, last on the fourth word.
      for (int i = 0; i < 4; i++) load_word(img4[i], i == 3);
      check("img4_stall", stall, 1'b0);
      check("img4_words", loaded_words, 4);
      check("img4_nop_on_last", inst, 32'h0);
      for (int i = 0; i < 4; i++) begin
         fetch(16'(i));
         check("img4_fetch", inst, img4[i]);
      end

      // Loader gaps: valid pattern 1,0,0,1,0,1(last).
      reload_pulse();
      check("reload_stall", stall, 1'b1);
      load_word(32'hAAAA_0001, 1'b0);
      gap(); gap();
      load_word(32'hBBBB_0002, 1'b0);
      gap();
      load_word(32'hCCCC_0003, 1'b1);
      check("gaps_words", loaded_words, 3);
      fetch(16'd0); check("gaps_a", inst, 32'hAAAA_0001);
      fetch(16'd1); check("gaps_b", inst, 32'hBBBB_0002);
      fetch(16'd2); check("gaps_c", inst, 32'hCCCC_0003);

      // Reload mid-run after a six-word image.
      reload_pulse();
      for (int i = 0; i < 6; i++) load_word(32'h5000_0000 + i, i == 5);
      fetch(16'd4); check("six_w4", inst, 32'h5000_0004);
      reload_pulse();
      load_word(32'hDEADBEEF, 1'b1);
      check("reload_words", loaded_words, 1);
      fetch(16'd0); check("reload_a0", inst, 32'hDEADBEEF);
      fetch(16'd5); check("reload_a5_old", inst, 32'h5000_0005);

      // Reset mid-load.
      reload_pulse();
      load_word(32'h7000_0000, 1'b0);
      load_word(32'h7000_0001, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h9999_9999, 1'b0, 16'h0);
      check("midrst_words", loaded_words, 0);
      load_word(32'hCAFE0000, 1'b1);
      check("midrst_words1", loaded_words, 1);
      fetch(16'd0); check("midrst_a0", inst, 32'hCAFE0000);
      fetch(16'd1); check("midrst_a1_kept", inst, 32'h7000_0001);

      // Overflow: full memory without a last marker.
      reload_pulse();
      for (int i = 0; i < DEPTH; i++) begin
         check("ovf_running_stall", stall, 1'b1);
         load_word(32'hA0 + i, 1'b0);
      end
      check("ovf_stall", stall, 1'b0);
      check("ovf_err", load_err, 1'b1);
      check("ovf_words", loaded_words, DEPTH);
      fetch(16'h000B); check("ovf_alias", inst, 32'hA3);
      fetch(16'hFFF8); check("ovf_alias_hi", inst, 32'hA0);
      reload_pulse();
      check("ovf_clear_err", load_err, 1'b0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 64) != 0, ($urandom % 12) == 0, 1'($urandom),
             $urandom, ($urandom % 5) == 0, 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
